// File: rtl/exec_pkg.sv
// Shared definitions for the CPU run/step sequencer: host command codes,
// sequencer states and step modes.
package exec_pkg;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_RUN   = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_USTEP = 3'd3;
    localparam logic [2:0] CMD_ISTEP = 3'd4;
    localparam logic [2:0] CMD_RESET = 3'd5;

    typedef enum logic [2:0] {
        ST_RST,
        ST_STOP,
        ST_PH_A,
        ST_PH_B,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_USTEP,
        MODE_ISTEP
    } mode_t;

endpackage

// File: rtl/exec_controller_phase_divider.sv
// Idle-cycle counter shared by both phases: samples div on each strobe and
// flags the last cycle of the phase (the strobe cycle itself when div is 0).
module phase_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             strobe,
    input  logic [DIV_W-1:0] div,
    output logic             expire
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (strobe) begin
            cnt <= (div == '0) ? '0 : div - DIV_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    always_comb begin
        expire = strobe ? (div == '0) : (cnt == '0);
    end

endmodule

// File: rtl/exec_controller.sv
// Run/step sequencer: generates the datapath and control phase strobes, the
// CPU reset and ctrlen, and obeys host run/stop/step/reset commands.
module exec_controller
    import exec_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    output logic             cmd_ready,
    input  logic [DIV_W-1:0] div,
    input  logic             brk_en,
    input  logic             hlt,
    input  logic             brk,
    input  logic             step_resetn,
    output logic             cpu_clk_en,
    output logic             cpu_iclk_en,
    output logic             cpu_rst,
    output logic             ctrlen,
    output logic             running,
    output logic             halted,
    output logic             brk_hit,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);

    state_t            state, state_next;
    mode_t             mode, mode_sel;
    logic [HOLD_W-1:0] hold;
    logic              stop_pend;
    logic              hlt_q, brk_q, srn_q;
    logic              hlt_s, brk_s, srn_s;
    logic              strobe, expire;
    logic              cmd_fire, is_reset, is_stop, is_go;
    logic              in_run, tick_done, brk_stop;

    assign strobe = cpu_clk_en | cpu_iclk_en;

    phase_divider #(
        .DIV_W(DIV_W)
    ) u_phase_divider (
        .clk   (clk),
        .rstn  (rstn),
        .strobe(strobe),
        .div   (div),
        .expire(expire)
    );

    always_comb begin
        cmd_fire  = cmd_valid && cmd_ready;
        is_reset  = cmd_fire && (cmd == CMD_RESET);
        is_stop   = cmd_fire && (cmd == CMD_STOP);
        is_go     = cmd_fire && (state == ST_STOP) &&
                    ((cmd == CMD_RUN) || (cmd == CMD_USTEP) || (cmd == CMD_ISTEP));
        mode_sel  = MODE_RUN;
        if (cmd == CMD_USTEP) mode_sel = MODE_USTEP;
        else if (cmd == CMD_ISTEP) mode_sel = MODE_ISTEP;
        in_run    = (state == ST_PH_A) || (state == ST_PH_B);
        tick_done = (state == ST_PH_B) && expire;
        // When div is 0 the decision falls on the B strobe cycle itself.
        hlt_s     = cpu_iclk_en ? hlt : hlt_q;
        brk_s     = cpu_iclk_en ? brk : brk_q;
        srn_s     = cpu_iclk_en ? step_resetn : srn_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_RST;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        brk_stop   = 1'b0;
        case (state)
            ST_RST:  if (hold == HOLD_W'(1)) state_next = ST_STOP;
            ST_STOP: if (is_go) state_next = ST_PH_A;
            ST_PH_A: if (expire) state_next = ST_PH_B;
            ST_PH_B: begin
                if (expire) begin
                    if (hlt_s) begin
                        state_next = ST_HALT;
                    end else if (brk_s && brk_en) begin
                        state_next = ST_STOP;
                        brk_stop   = 1'b1;
                    end else if (stop_pend || is_stop || (mode == MODE_USTEP) ||
                                 ((mode == MODE_ISTEP) && !srn_s)) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_PH_A;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
        if (is_reset) begin
            state_next = ST_RST;
            brk_stop   = 1'b0;
        end
    end

    always_comb begin
        cmd_ready = (state != ST_RST);
        ctrlen    = (state != ST_RST);
        cpu_rst   = (state == ST_RST);
        running   = in_run;
        halted    = (state == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rstn || is_reset) begin
            hold        <= HOLD_W'(RST_CYCLES);
            cpu_clk_en  <= 1'b0;
            cpu_iclk_en <= 1'b0;
            brk_hit     <= 1'b0;
            tick_cnt    <= '0;
            mode        <= MODE_RUN;
            stop_pend   <= 1'b0;
            hlt_q       <= 1'b0;
            brk_q       <= 1'b0;
            srn_q       <= 1'b1;
        end else begin
            cpu_clk_en  <= (state_next == ST_PH_A) && (state != ST_PH_A);
            cpu_iclk_en <= (state_next == ST_PH_B) && (state != ST_PH_B);
            if ((state == ST_RST) && (hold != '0)) hold <= hold - HOLD_W'(1);
            if (is_go) begin
                mode    <= mode_sel;
                brk_hit <= 1'b0;
            end
            if (brk_stop) brk_hit <= 1'b1;
            if (tick_done) tick_cnt <= tick_cnt + CNT_W'(1);
            if (in_run && (state_next != ST_PH_A) && (state_next != ST_PH_B))
                stop_pend <= 1'b0;
            else if (in_run && is_stop)
                stop_pend <= 1'b1;
            if (cpu_iclk_en) begin
                hlt_q <= hlt;
                brk_q <= brk;
                srn_q <= step_resetn;
            end
        end
    end

endmodule
